// File: rtl/clock_alarm_pkg.sv
// rtl/clock_alarm_pkg.sv - shared widths, limits, edit states and wrap helpers for the clock setter
package clock_alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

  typedef enum logic [2:0] {
    RUN,
    T_HOUR,
    T_MIN,
    A_HOUR,
    A_MIN
  } state_t;

  // Minutes never carry into hours; each field wraps on its own.
  function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
    return (h >= MAX_HOUR) ? '0 : h + HOUR_W'(1);
  endfunction

  function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] m);
    return (m >= MAX_MIN) ? '0 : m + MIN_W'(1);
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// rtl/clock_set_ctrl_if.sv - buttons, running time and setter outputs bundled for the clock setter
interface clock_set_ctrl_if;
  import clock_alarm_pkg::*;

  logic              btn_mode;
  logic              btn_inc;
  logic              tick_1hz;
  logic [HOUR_W-1:0] cur_hour;
  logic [MIN_W-1:0]  cur_min;
  logic              time_load;
  logic [HOUR_W-1:0] set_hour;
  logic [MIN_W-1:0]  set_min;
  logic [HOUR_W-1:0] alarm_hour;
  logic [MIN_W-1:0]  alarm_min;
  logic              editing;
  logic [1:0]        field;

  modport slave (
    input  btn_mode, btn_inc, tick_1hz, cur_hour, cur_min,
    output time_load, set_hour, set_min, alarm_hour, alarm_min, editing, field
  );

  modport master (
    output btn_mode, btn_inc, tick_1hz, cur_hour, cur_min,
    input  time_load, set_hour, set_min, alarm_hour, alarm_min, editing, field
  );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, stability counter and press pulse for one raw button
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The counter runs only while the synchronised input disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - mode FSM that edits the running time and the alarm from two debounced buttons
module clock_set_ctrl
  import clock_alarm_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int TIMEOUT_S   = 30,
  parameter int ALARM_HOUR  = 7,
  parameter int ALARM_MIN   = 30
) (
  input logic              clk,
  input logic              rst_n,
  clock_set_ctrl_if.slave  bus
);

  localparam int DB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int IDLE_W    = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);

  logic mode_level, mode_press;
  logic inc_level, inc_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.btn_mode),
    .level (mode_level),
    .press (mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.btn_inc),
    .level (inc_level),
    .press (inc_press)
  );

  state_t            state, state_d;
  logic [HOUR_W-1:0] edit_hour, edit_hour_d;
  logic [MIN_W-1:0]  edit_min, edit_min_d;
  logic [HOUR_W-1:0] alarm_hour_q, alarm_hour_d;
  logic [MIN_W-1:0]  alarm_min_q, alarm_min_d;
  logic [HOUR_W-1:0] set_hour_q, set_hour_d;
  logic [MIN_W-1:0]  set_min_q, set_min_d;
  logic              time_load_q, time_load_d;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      edit_hour    <= '0;
      edit_min     <= '0;
      alarm_hour_q <= HOUR_W'(ALARM_HOUR);
      alarm_min_q  <= MIN_W'(ALARM_MIN);
      set_hour_q   <= '0;
      set_min_q    <= '0;
      time_load_q  <= 1'b0;
      idle_cnt     <= '0;
    end else begin
      state        <= state_d;
      edit_hour    <= edit_hour_d;
      edit_min     <= edit_min_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      set_hour_q   <= set_hour_d;
      set_min_q    <= set_min_d;
      time_load_q  <= time_load_d;
      idle_cnt     <= idle_cnt_d;
    end
  end

  // Priority: mode press, then inc press, then the idle tick; any press restarts the idle count.
  always_comb begin
    state_d      = state;
    edit_hour_d  = edit_hour;
    edit_min_d   = edit_min;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    set_hour_d   = set_hour_q;
    set_min_d    = set_min_q;
    time_load_d  = 1'b0;
    idle_cnt_d   = idle_cnt;

    if (state == RUN) begin
      idle_cnt_d = '0;
      if (mode_press) begin
        state_d     = T_HOUR;
        edit_hour_d = bus.cur_hour;
        edit_min_d  = bus.cur_min;
      end
    end else if (mode_press) begin
      idle_cnt_d = '0;
      case (state)
        T_HOUR: state_d = T_MIN;
        T_MIN: begin
          state_d     = A_HOUR;
          time_load_d = 1'b1;
          set_hour_d  = edit_hour;
          set_min_d   = edit_min;
          edit_hour_d = alarm_hour_q;
          edit_min_d  = alarm_min_q;
        end
        A_HOUR: state_d = A_MIN;
        A_MIN: begin
          state_d      = RUN;
          alarm_hour_d = edit_hour;
          alarm_min_d  = edit_min;
        end
        default: state_d = RUN;
      endcase
    end else if (inc_press) begin
      idle_cnt_d = '0;
      if (state == T_HOUR || state == A_HOUR) begin
        edit_hour_d = hour_inc(edit_hour);
      end else begin
        edit_min_d = min_inc(edit_min);
      end
    end else if (bus.tick_1hz) begin
      if (idle_cnt >= IDLE_LAST) begin
        state_d    = RUN;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt + IDLE_W'(1);
      end
    end
  end

  assign bus.time_load  = time_load_q;
  assign bus.set_hour   = set_hour_q;
  assign bus.set_min    = set_min_q;
  assign bus.alarm_hour = alarm_hour_q;
  assign bus.alarm_min  = alarm_min_q;
  assign bus.editing    = (state != RUN);
  assign bus.field      = (state == T_MIN || state == A_MIN) ? 2'd1 : 2'd0;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - scoreboard bench for clock_set_ctrl with directed button sequences
module tb_clock_set_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(
    .CLK_FREQ    (1000),
    .DEBOUNCE_MS (3),
    .TIMEOUT_S   (4),
    .ALARM_HOUR  (7),
    .ALARM_MIN   (30)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int strobes = 0;
  int inc_presses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every time_load strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.time_load === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual=%0d:%0d required=no_strobe", bus.set_hour, bus.set_min);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_hour", 32'(bus.set_hour), 32'(e.h));
        check("strobe_min", 32'(bus.set_min), 32'(e.m));
      end
    end
  end

  always @(negedge clk) begin
    if (dut.u_db_inc.press === 1'b1) inc_presses++;
  end

  task automatic press_btn(input bit m, input bit i);
    @(posedge clk); #1;
    bus.btn_mode = m;
    bus.btn_inc  = i;
    repeat (8) @(posedge clk);
    #1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic tick;
    @(posedge clk); #1;
    bus.tick_1hz = 1'b1;
    @(posedge clk); #1;
    bus.tick_1hz = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic expect_load(input logic [4:0] h, input logic [5:0] m);
    exp_t e;
    e.h = h;
    e.m = m;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_time_load"}, 32'(bus.time_load), 32'd0);
    check({tag, "_set_hour"}, 32'(bus.set_hour), 32'd0);
    check({tag, "_set_min"}, 32'(bus.set_min), 32'd0);
    check({tag, "_editing"}, 32'(bus.editing), 32'd0);
    check({tag, "_field"}, 32'(bus.field), 32'd0);
    check({tag, "_alarm_hour"}, 32'(bus.alarm_hour), 32'd7);
    check({tag, "_alarm_min"}, 32'(bus.alarm_min), 32'd30);
  endtask

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.tick_1hz = 1'b0;
    bus.cur_hour = 5'd0;
    bus.cur_min  = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: short glitch ignored, long hold gives exactly one press
    @(posedge clk); #1;
    bus.btn_inc = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.btn_inc = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("glitch_presses", 32'(inc_presses), 32'd0);
    bus.btn_inc = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.btn_inc = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("hold_presses", 32'(inc_presses), 32'd1);
    check("run_editing", 32'(bus.editing), 32'd0);

    // 2: set time 13:45 -> 14:47
    bus.cur_hour = 5'd13;
    bus.cur_min  = 6'd45;
    press_btn(1, 0);
    check("t_hour_editing", 32'(bus.editing), 32'd1);
    check("t_hour_field", 32'(bus.field), 32'd0);
    press_btn(0, 1);
    press_btn(1, 0);
    check("t_min_field", 32'(bus.field), 32'd1);
    press_btn(0, 1);
    press_btn(0, 1);
    expect_load(5'd14, 6'd47);
    press_btn(1, 0);
    check("a_hour_editing", 32'(bus.editing), 32'd1);
    check("a_hour_field", 32'(bus.field), 32'd0);

    // 3: alarm 07:30 -> 10:01
    repeat (3) press_btn(0, 1);
    press_btn(1, 0);
    for (int k = 0; k < 31; k++) press_btn(0, 1);
    press_btn(1, 0);
    check("alarm_hour_set", 32'(bus.alarm_hour), 32'd10);
    check("alarm_min_set", 32'(bus.alarm_min), 32'd1);
    check("back_to_run", 32'(bus.editing), 32'd0);

    // 4: wrap 23 -> 0 and 59 -> 0 without carry
    bus.cur_hour = 5'd23;
    bus.cur_min  = 6'd59;
    press_btn(1, 0);
    press_btn(0, 1);
    press_btn(1, 0);
    press_btn(0, 1);
    expect_load(5'd0, 6'd0);
    press_btn(1, 0);
    press_btn(1, 0);
    press_btn(1, 0);
    check("alarm_hour_kept", 32'(bus.alarm_hour), 32'd10);
    check("alarm_min_kept", 32'(bus.alarm_min), 32'd1);

    // 5: simultaneous mode+inc, then idle timeout in A_MIN
    bus.cur_hour = 5'd5;
    bus.cur_min  = 6'd6;
    press_btn(1, 0);
    press_btn(1, 1);
    check("simul_field", 32'(bus.field), 32'd1);
    expect_load(5'd5, 6'd6);
    press_btn(1, 0);
    press_btn(1, 0);
    press_btn(0, 1);
    repeat (3) tick();
    check("pre_timeout_editing", 32'(bus.editing), 32'd1);
    check("pre_timeout_field", 32'(bus.field), 32'd1);
    tick();
    check("timeout_editing", 32'(bus.editing), 32'd0);
    check("timeout_alarm_hour", 32'(bus.alarm_hour), 32'd10);
    check("timeout_alarm_min", 32'(bus.alarm_min), 32'd1);

    // 6: async reset mid A_HOUR
    press_btn(1, 0);
    press_btn(1, 0);
    expect_load(5'd5, 6'd6);
    press_btn(1, 0);
    press_btn(0, 1);
    check("pre_reset_editing", 32'(bus.editing), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("post_reset_editing", 32'(bus.editing), 32'd0);

    check("pending_loads", 32'(exp_q.size()), 32'd0);
    check("strobe_count", 32'(strobes), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
